// File: rtl/mantissa_normalizer_if.sv
// Handshake and data bundle for mantissa_normalizer: sum/exp/sign in, packed fraction/exp/flags out.
// Valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
// The producer holds the data stable while valid is high, and ready never depends on valid.
interface mantissa_normalizer_if #(
   parameter int MANTISSA_WIDTH = 23,
   parameter int EXP_WIDTH      = 8
);
   logic                      in_valid;
   logic                      in_ready;
   logic [MANTISSA_WIDTH+4:0] sum_in;
   logic [EXP_WIDTH-1:0]      exp_in;
   logic                      sign_in;
   logic                      out_valid;
   logic                      out_ready;
   logic [MANTISSA_WIDTH-1:0] mantissa_out;
   logic [EXP_WIDTH-1:0]      exp_out;
   logic                      sign_out;
   logic                      zero;
   logic                      overflow;
   logic                      underflow;
   logic                      inexact;

   modport master (
      output in_valid, sum_in, exp_in, sign_in, out_ready,
      input  in_ready, out_valid, mantissa_out, exp_out, sign_out,
             zero, overflow, underflow, inexact
   );

   modport slave (
      input  in_valid, sum_in, exp_in, sign_in, out_ready,
      output in_ready, out_valid, mantissa_out, exp_out, sign_out,
             zero, overflow, underflow, inexact
   );
endinterface

// File: rtl/mantissa_normalizer.sv
// Iterative post-add normalizer/rounder: one left shift per cycle, then a single rounding step.
// NORMALIZER_RNE_EN selects round-to-nearest-even; without it the fraction is truncated.
module mantissa_normalizer #(
   parameter int MANTISSA_WIDTH = 23,
   parameter int EXP_WIDTH      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   mantissa_normalizer_if.slave    bus,
   output logic [2:0]              dbg_state
);
   localparam int W = MANTISSA_WIDTH + 5;
   localparam logic [EXP_WIDTH-1:0] EMAX = '1;
   localparam logic [EXP_WIDTH-1:0] EONE = EXP_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      NORM  = 3'd1,
      SHIFT = 3'd2,
      ROUND = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                    state_q, state_d;
   logic [W-1:0]              m_q, m_d;
   logic [EXP_WIDTH-1:0]      e_q, e_d;
   logic                      s_q, s_d;
   logic [MANTISSA_WIDTH-1:0] frac_q, frac_d;
   logic                      zero_q, zero_d;
   logic                      ovf_q, ovf_d;
   logic                      unf_q, unf_d;
   logic                      inx_q, inx_d;

   logic [W-1:0]              m_norm;
   logic [EXP_WIDTH-1:0]      e_norm;
   logic                      e_wrap;
   logic                      up;
   logic [MANTISSA_WIDTH:0]   frac_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         m_q     <= '0;
         e_q     <= '0;
         s_q     <= 1'b0;
         frac_q  <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         inx_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         e_q     <= e_d;
         s_q     <= s_d;
         frac_q  <= frac_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         inx_q   <= inx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      e_d      = e_q;
      s_d      = s_q;
      frac_d   = frac_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      inx_d    = inx_q;
      m_norm   = m_q;
      e_norm   = e_q;
      e_wrap   = 1'b0;
      up       = 1'b0;
      frac_sum = '0;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               m_d    = bus.sum_in;
               e_d    = bus.exp_in;
               s_d    = bus.sign_in;
               frac_d = '0;
               zero_d = 1'b0;
               ovf_d  = 1'b0;
               unf_d  = 1'b0;
               inx_d  = 1'b0;
               if (bus.sum_in == '0) begin
                  zero_d  = 1'b1;
                  e_d     = '0;
                  state_d = DONE;
               end else begin
                  state_d = NORM;
               end
            end
         end

         NORM: begin
            // Carry-out: shift right once, folding the lost bit into sticky.
            if (m_q[W-1]) begin
               m_norm = {1'b0, m_q[W-1:2], m_q[1] | m_q[0]};
               e_norm = e_q + EONE;
               e_wrap = (e_q == EMAX);
            end
            m_d = m_norm;
            e_d = e_norm;
            if (e_norm == EMAX || e_wrap) begin
               e_d     = EMAX;
               frac_d  = '0;
               ovf_d   = 1'b1;
               inx_d   = 1'b1;
               state_d = DONE;
            end else if (m_norm[W-2]) begin
               state_d = ROUND;
            end else begin
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            // Hidden bit is always 0 on entry; decide on the shifted value to save a cycle.
            if (e_q > EONE) begin
               m_d = {m_q[W-2:0], 1'b0};
               e_d = e_q - EONE;
               if (m_q[W-3]) state_d = ROUND;
            end else begin
               e_d     = '0;
               unf_d   = 1'b1;
               state_d = ROUND;
            end
         end

         ROUND: begin
            inx_d = |m_q[2:0];
`ifdef NORMALIZER_RNE_EN
            up = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
`else
            up = 1'b0;
`endif
            frac_sum = {1'b0, m_q[W-3:3]} + {{MANTISSA_WIDTH{1'b0}}, up};
            frac_d   = frac_sum[MANTISSA_WIDTH-1:0];
            // Fraction wrap carries into the exponent; a subnormal becomes e=1 here.
            if (frac_sum[MANTISSA_WIDTH]) begin
               frac_d = '0;
               e_d    = e_q + EONE;
               if (e_q + EONE == EMAX) ovf_d = 1'b1;
            end
            state_d = DONE;
         end

         DONE: begin
            if (bus.out_ready) begin
               zero_d  = 1'b0;
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               inx_d   = 1'b0;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Results are only visible in DONE so intermediate flag updates never leak out.
   assign bus.in_ready     = (state_q == IDLE);
   assign bus.out_valid    = (state_q == DONE);
   assign bus.mantissa_out = bus.out_valid ? frac_q : '0;
   assign bus.exp_out      = bus.out_valid ? e_q : '0;
   assign bus.sign_out     = bus.out_valid & s_q;
   assign bus.zero         = bus.out_valid & zero_q;
   assign bus.overflow     = bus.out_valid & ovf_q;
   assign bus.underflow    = bus.out_valid & unf_q;
   assign bus.inexact      = bus.out_valid & inx_q;
   assign dbg_state        = state_q;
endmodule

// File: tb/tb_mantissa_normalizer.sv
// Bench for mantissa_normalizer: directed vectors plus random sums checked against an arithmetic model.
// Follows NORMALIZER_RNE_EN the same way as the design build.
module tb_mantissa_normalizer;
   localparam int MW = 23;
   localparam int EW = 8;

   typedef struct packed {
      logic          zero;
      logic          ovf;
      logic          unf;
      logic          inx;
      logic          sign;
      logic [EW-1:0] exp;
      logic [MW-1:0] mant;
   } res_t;
   localparam int RES_W = $bits(res_t);

   logic       clk;
   logic       rst;
   logic [2:0] dbg_state;
   int         tests_run;
   int         fail_cnt;

   logic [RES_W-1:0] exp_q[$];
   int               lat_q[$];

   mantissa_normalizer_if #(.MANTISSA_WIDTH(MW), .EXP_WIDTH(EW)) bus ();

   mantissa_normalizer #(.MANTISSA_WIDTH(MW), .EXP_WIDTH(EW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Reference model: value-level normalization via leading-zero count, then rounding.
   function automatic void model(input logic [MW+4:0] sum, input int ein, input logic sgn,
                                 output res_t r, output int lat);
      longint m;
      longint frac;
      int     e, msb, lz, sh;
      bit     uf, g, rb, sb, l, upb;
      r = '0;
      r.sign = sgn;
      if (sum == '0) begin
         r.zero = 1'b1;
         lat = 1;
         return;
      end
      m = longint'(sum);
      e = ein;
      if (m >= (64'sd1 << 27)) begin
         m = (m >> 1) | (m & 1);
         e = e + 1;
      end
      if (e >= 255) begin
         r.ovf = 1'b1;
         r.inx = 1'b1;
         r.exp = 8'hFF;
         lat = 2;
         return;
      end
      msb = 0;
      for (int i = 0; i < 27; i++) if (((m >> i) & 1) != 0) msb = i;
      lz = 26 - msb;
      uf = 1'b0;
      if (lz <= e - 1) begin
         sh = lz;
         e  = e - lz;
      end else begin
         sh = (e - 1 > 0) ? e - 1 : 0;
         e  = 0;
         uf = 1'b1;
      end
      m = m << sh;
      lat = 3 + sh + int'(uf);
      frac = (m >> 3) & 64'h7F_FFFF;
      g  = ((m >> 2) & 1) != 0;
      rb = ((m >> 1) & 1) != 0;
      sb = (m & 1) != 0;
      l  = ((m >> 3) & 1) != 0;
`ifdef NORMALIZER_RNE_EN
      upb = g && (rb || sb || l);
`else
      upb = 1'b0;
`endif
      frac = frac + longint'(upb);
      if (frac == (64'sd1 << MW)) begin
         frac = 0;
         e = e + 1;
         if (e == 255) r.ovf = 1'b1;
      end
      r.mant = r.ovf ? '0 : MW'(frac);
      r.exp  = EW'(e);
      r.unf  = uf;
      r.inx  = g | rb | sb;
   endfunction

   // Driver tasks.
   task automatic send(input logic [MW+4:0] sum, input logic [EW-1:0] e, input logic sgn);
      res_t r;
      int   lat;
      int   w;
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready_before_send", bus.in_ready, 1);
      bus.sum_in   = sum;
      bus.exp_in   = e;
      bus.sign_in  = sgn;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      model(sum, int'(e), sgn, r, lat);
      exp_q.push_back(r);
      lat_q.push_back(lat);
   endtask

   // Scoreboard: waits for a result, checks latency and fields, optionally stalls, then accepts.
   task automatic collect(input int hold);
      res_t er;
      res_t got;
      int   el, cnt;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!bus.out_valid && cnt < 200);
      er = exp_q.pop_front();
      el = lat_q.pop_front();
      got = {bus.zero, bus.overflow, bus.underflow, bus.inexact, bus.sign_out,
             bus.exp_out, bus.mantissa_out};
      chk("latency", cnt, el);
      chk("out_valid", bus.out_valid, 1);
      chk("in_ready_busy", bus.in_ready, 0);
      chk("mantissa", got.mant, er.mant);
      chk("exponent", got.exp, er.exp);
      chk("flags_zovui", {got.zero, got.ovf, got.unf, got.inx, got.sign},
          {er.zero, er.ovf, er.unf, er.inx, er.sign});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_in_ready", bus.in_ready, 0);
         chk("hold_result", {bus.zero, bus.overflow, bus.underflow, bus.inexact, bus.sign_out,
                             bus.exp_out, bus.mantissa_out}, er);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      chk("released_valid", bus.out_valid, 0);
      chk("released_in_ready", bus.in_ready, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      logic [MW+4:0] rs;
      tests_run     = 0;
      fail_cnt      = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.sum_in    = '0;
      bus.exp_in    = '0;
      bus.sign_in   = 1'b0;
      bus.out_ready = 1'b0;
      do_reset();

      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_outputs", {bus.zero, bus.overflow, bus.underflow, bus.inexact, bus.sign_out,
                          bus.exp_out, bus.mantissa_out}, 0);
      chk("rst_state", dbg_state, 0);

      // Already normalized, carry without and with sticky.
      send(28'h4000000, 8'd127, 1'b0); collect(0);
      send(28'h8000000, 8'd127, 1'b1); collect(0);
      send(28'h8000001, 8'd127, 1'b0); collect(0);

      // Full cancellation: 23 left shifts, exponent 104, 26 cycles.
      send(28'h0000008, 8'd127, 1'b0); collect(0);

      // Rounding boundaries (tie-to-even, round-up, wrap into overflow).
      send(28'h4000004, 8'd127, 1'b0); collect(0);
      send(28'h400000C, 8'd127, 1'b0); collect(0);
      send(28'h7FFFFFC, 8'd254, 1'b0); collect(0);
      send(28'h7FFFFFF, 8'd100, 1'b1); collect(0);

      // Exponent limits: carry into EMAX, and underflow from a small exponent.
      send(28'h8000000, 8'd254, 1'b0); collect(0);
      send(28'h0000010, 8'd3, 1'b0);   collect(0);
      send(28'h2000000, 8'd1, 1'b1);   collect(0);

      // Zero with a stalled consumer.
      send(28'h0000000, 8'd127, 1'b1); collect(5);

      // Reset in the middle of the shift loop aborts the operation.
      send(28'h0000008, 8'd127, 1'b0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_in_ready", bus.in_ready, 1);
      rst = 1'b0;
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("abort_no_result", bus.out_valid, 0);
      end
      send(28'h4000000, 8'd127, 1'b0); collect(0);

      // Random sums across magnitudes and exponents.
      for (int n = 0; n < 60; n++) begin
         rs = 28'($urandom()) >> $urandom_range(0, 27);
         if ($urandom_range(0, 9) == 0) rs = '0;
         send(rs, (n % 4 == 0) ? 8'($urandom_range(1, 30)) : 8'($urandom_range(1, 254)),
              1'($urandom_range(0, 1)));
         collect($urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end
endmodule
